core_wb: RTL and testbench
==========================

CORE_WB -- requirements
Module: core_wb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: max cycles to wait for load data before error.
REQ-002 SHALL have ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- wb_vld_in  in  1  instruction from mem stage valid
- wb_kill_in  in  1  flush current/pending instruction
- wb_src_in  in  2  result select: 0 ALU, 1 LOAD, 2 IMM, 3 PC+4
- wb_we_reg_file_in  in  1  instruction writes register file
- wb_rd_in  in  5  destination register
- wb_alu_result_in  in  32  ALU result / load address
- wb_sx_imm_in  in  32  sign-extended immediate
- wb_pc_4_in  in  32  PC+4
- wb_sx_type_in  in  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
- dmem_ack_in  in  1  load data valid
- dmem_rdata_in  in  32  load data word
- rf_we_out  out  1  register-file write enable
- rf_rd_out  out  5  register-file write index
- rf_wdata_out  out  32  register-file write data
- wb_stall_out  out  1  hold upstream stages
- wb_bp_vld_out  out  1  bypass entry valid
- wb_bp_rd_out  out  5  bypass register index
- wb_bp_data_out  out  32  bypass data
- wb_err_out  out  1  sticky load-timeout error

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, ERR.
REQ-004 SHALL, in IDLE, accept an instruction when wb_vld_in=1 and wb_kill_in=0.
REQ-005 SHALL, for accepted non-LOAD instruction, drive rf_we_out/rf_rd_out/rf_wdata_out from registers on the next cycle (1-cycle latency).
REQ-006 SHALL, for accepted LOAD with dmem_ack_in=1 same cycle, write extended data next cycle and remain in IDLE.
REQ-007 SHALL, for accepted LOAD with dmem_ack_in=0, capture rd, we, sx_type, address[1:0] and enter WAIT.
REQ-008 SHALL, in WAIT, on dmem_ack_in=1 write extended data next cycle and return to IDLE.
REQ-009 SHALL assert wb_stall_out combinationally when state=WAIT, state=ERR, or (IDLE, accepted LOAD, dmem_ack_in=0); upstream holds inputs while stalled.
REQ-010 SHALL extract load data by address[1:0]: LW whole word (offset ignored); LH/LHU halfword at addr[1]; LB/LBU byte at addr[1:0]; LH/LB sign-extend, LHU/LBU zero-extend; reserved sx_type 101-111 treated as LW.
REQ-011 SHALL force rf_we_out=0 when rd=0 or wb_we_reg_file_in=0; rf_we_out is a single-cycle pulse per instruction.
REQ-012 SHALL, on wb_kill_in=1 in WAIT, return to IDLE with no write; ack in same cycle is discarded.
REQ-013 SHALL count cycles in WAIT from 0; counter reaching TIMEOUT_CYC without ack SHALL enter ERR.
REQ-014 SHALL, in ERR, hold wb_err_out=1 and wb_stall_out=1, ignore ack and kill, until reset.
REQ-015 SHALL update wb_bp_vld_out/rd/data on every rf write with the same values, holding them otherwise; rd=0 writes do not update.
REQ-016 SHALL ignore dmem_ack_in in IDLE when no LOAD is being accepted.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously enter IDLE and clear counter, rf_we_out, rf_rd_out, rf_wdata_out, wb_bp_vld_out, wb_bp_rd_out, wb_bp_data_out, wb_err_out to 0; wb_stall_out=0.
REQ-018 SHALL abandon a pending WAIT on reset with no write after release.

Verification
REQ-019 ALU op rd=5, alu=0x1234_5678, src=0 -> next cycle rf_we_out=1, rd=5, wdata=0x1234_5678; bypass matches.
REQ-020 LB, addr low=2'b11, ack same cycle, rdata=0x8000_0000 -> wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-021 LH, addr[1]=1, ack after 3 cycles, rdata=0x8001_0000 -> stall high 3 cycles, then wdata=0xFFFF_8001, stall low.
REQ-022 LOAD waiting, kill asserted with ack same cycle -> IDLE, no rf_we_out pulse.
REQ-023 TIMEOUT_CYC=4, no ack -> ERR after 4 WAIT cycles, wb_err_out=1, stall stays high; rst_n low clears both.
REQ-024 Instruction rd=0, we=1 -> rf_we_out stays 0, bypass unchanged.

Source files
------------

// File: rtl/core_wb.sv
// core_wb: write-back stage.
// Takes the instruction leaving the memory stage, selects its result (ALU, load, immediate or
// PC+4) and produces a registered register-file write plus a matching bypass entry. A load whose
// data is not ready in the accept cycle parks the stage in StWait until dmem_ack_in. If no ack
// arrives within TIMEOUT_CYC cycles, the stage locks into StErr until reset.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   wb_vld_in / wb_kill_in  incoming instruction valid / flush
//   wb_src_in               result select: 0 ALU, 1 LOAD, 2 IMM, 3 PC+4
//   wb_we_reg_file_in       instruction writes the register file
//   wb_rd_in                destination register
//   wb_alu_result_in        ALU result, also the load address
//   wb_sx_imm_in            sign-extended immediate
//   wb_pc_4_in              PC+4
//   wb_sx_type_in           load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
//   dmem_ack_in             load data valid
//   dmem_rdata_in           load data word
//   rf_we_out/rd/wdata      register-file write port (registered, single-cycle we pulse)
//   wb_stall_out            hold upstream stages (combinational)
//   wb_bp_vld/rd/data_out   bypass entry; it mirrors the last real register-file write
//   wb_err_out              sticky load-timeout error
module core_wb #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_vld_in,
  input  logic        wb_kill_in,
  input  logic [1:0]  wb_src_in,
  input  logic        wb_we_reg_file_in,
  input  logic [4:0]  wb_rd_in,
  input  logic [31:0] wb_alu_result_in,
  input  logic [31:0] wb_sx_imm_in,
  input  logic [31:0] wb_pc_4_in,
  input  logic [2:0]  wb_sx_type_in,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        rf_we_out,
  output logic [4:0]  rf_rd_out,
  output logic [31:0] rf_wdata_out,
  output logic        wb_stall_out,
  output logic        wb_bp_vld_out,
  output logic [4:0]  wb_bp_rd_out,
  output logic [31:0] wb_bp_data_out,
  output logic        wb_err_out
);

  localparam int unsigned CntW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      ld_rd_q;
  logic            ld_we_q;
  logic [2:0]      ld_sx_q;
  logic [1:0]      ld_off_q;

  logic            rf_we_q;
  logic [4:0]      rf_rd_q;
  logic [31:0]     rf_wdata_q;
  logic            bp_vld_q;
  logic [4:0]      bp_rd_q;
  logic [31:0]     bp_data_q;
  logic            err_q;

  logic            accept;
  logic            is_load;
  logic            wr_req;
  logic            wr_we;
  logic [4:0]      wr_rd;
  logic [31:0]     wr_data;
  logic            wr_fire;

  // Extract and extend load data; reserved types fall back to a whole-word load.
  function automatic logic [31:0] load_ext(input logic [2:0]  sx,
                                           input logic [1:0]  off,
                                           input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? d[31:16] : d[15:0];
    unique case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    case (sx)
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = {16'h0000, h};
      3'b011:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept  = (state_q == StIdle) && wb_vld_in && !wb_kill_in;
  assign is_load = (wb_src_in == 2'd1);

  assign wb_stall_out = (state_q == StWait) || (state_q == StErr) ||
                        (accept && is_load && !dmem_ack_in);

  // Write request for the current cycle; registered into the rf port below.
  always_comb begin
    wr_req  = 1'b0;
    wr_we   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    if (accept) begin
      wr_rd = wb_rd_in;
      wr_we = wb_we_reg_file_in;
      unique case (wb_src_in)
        2'd0: begin
          wr_req  = 1'b1;
          wr_data = wb_alu_result_in;
        end
        2'd1: begin
          wr_req  = dmem_ack_in;
          wr_data = load_ext(wb_sx_type_in, wb_alu_result_in[1:0], dmem_rdata_in);
        end
        2'd2: begin
          wr_req  = 1'b1;
          wr_data = wb_sx_imm_in;
        end
        default: begin
          wr_req  = 1'b1;
          wr_data = wb_pc_4_in;
        end
      endcase
    end else if ((state_q == StWait) && dmem_ack_in && !wb_kill_in) begin
      wr_req  = 1'b1;
      wr_rd   = ld_rd_q;
      wr_we   = ld_we_q;
      wr_data = load_ext(ld_sx_q, ld_off_q, dmem_rdata_in);
    end
  end

  // x0 is never written, so it never reaches the bypass either.
  assign wr_fire = wr_req && wr_we && (wr_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ld_rd_q    <= 5'd0;
      ld_we_q    <= 1'b0;
      ld_sx_q    <= 3'd0;
      ld_off_q   <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
      bp_vld_q   <= 1'b0;
      bp_rd_q    <= 5'd0;
      bp_data_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q <= wr_fire;
      if (wr_fire) begin
        rf_rd_q    <= wr_rd;
        rf_wdata_q <= wr_data;
        bp_vld_q   <= 1'b1;
        bp_rd_q    <= wr_rd;
        bp_data_q  <= wr_data;
      end

      case (state_q)
        StIdle: begin
          if (accept && is_load && !dmem_ack_in) begin
            ld_rd_q  <= wb_rd_in;
            ld_we_q  <= wb_we_reg_file_in;
            ld_sx_q  <= wb_sx_type_in;
            ld_off_q <= wb_alu_result_in[1:0];
            cnt_q    <= '0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          // Kill wins over a same-cycle ack; the ack data is dropped.
          if (wb_kill_in || dmem_ack_in) begin
            state_q <= StIdle;
          end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StErr: begin
          state_q <= StErr;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rf_we_out      = rf_we_q;
  assign rf_rd_out      = rf_rd_q;
  assign rf_wdata_out   = rf_wdata_q;
  assign wb_bp_vld_out  = bp_vld_q;
  assign wb_bp_rd_out   = bp_rd_q;
  assign wb_bp_data_out = bp_data_q;
  assign wb_err_out     = err_q;

endmodule

// File: tb/tb_core_wb.sv
// Testbench for core_wb (TIMEOUT_CYC = 4). Expected register-file writes are queued as stimulus
// is driven; a negedge monitor pops and compares every write the DUT produces.
module tb_core_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_vld_in;
  logic        wb_kill_in;
  logic [1:0]  wb_src_in;
  logic        wb_we_reg_file_in;
  logic [4:0]  wb_rd_in;
  logic [31:0] wb_alu_result_in;
  logic [31:0] wb_sx_imm_in;
  logic [31:0] wb_pc_4_in;
  logic [2:0]  wb_sx_type_in;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic        rf_we_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_wdata_out;
  logic        wb_stall_out;
  logic        wb_bp_vld_out;
  logic [4:0]  wb_bp_rd_out;
  logic [31:0] wb_bp_data_out;
  logic        wb_err_out;

  always #5 clk = ~clk;

  core_wb #(.TIMEOUT_CYC(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wb_vld_in         (wb_vld_in),
    .wb_kill_in        (wb_kill_in),
    .wb_src_in         (wb_src_in),
    .wb_we_reg_file_in (wb_we_reg_file_in),
    .wb_rd_in          (wb_rd_in),
    .wb_alu_result_in  (wb_alu_result_in),
    .wb_sx_imm_in      (wb_sx_imm_in),
    .wb_pc_4_in        (wb_pc_4_in),
    .wb_sx_type_in     (wb_sx_type_in),
    .dmem_ack_in       (dmem_ack_in),
    .dmem_rdata_in     (dmem_rdata_in),
    .rf_we_out         (rf_we_out),
    .rf_rd_out         (rf_rd_out),
    .rf_wdata_out      (rf_wdata_out),
    .wb_stall_out      (wb_stall_out),
    .wb_bp_vld_out     (wb_bp_vld_out),
    .wb_bp_rd_out      (wb_bp_rd_out),
    .wb_bp_data_out    (wb_bp_data_out),
    .wb_err_out        (wb_err_out)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  int          n_exp = 0;
  logic        bp_vld_m;
  logic [4:0]  bp_rd_m;
  logic [31:0] bp_data_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load extraction, written as shifts rather than a mux.
  function automatic logic [31:0] ref_ld(input logic [2:0] sx, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] hs;
    logic [31:0] bs;
    hs = w >> {off[1], 4'b0000};
    bs = w >> {off, 3'b000};
    if (sx == 3'b001)      return {{16{hs[15]}}, hs[15:0]};
    else if (sx == 3'b010) return {16'h0000, hs[15:0]};
    else if (sx == 3'b011) return {{24{bs[7]}}, bs[7:0]};
    else if (sx == 3'b100) return {24'h000000, bs[7:0]};
    else                   return w;
  endfunction

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
    n_exp++;
    bp_vld_m  = 1'b1;
    bp_rd_m   = rd;
    bp_data_m = data;
  endtask

  task automatic drive(input logic [1:0] src, input logic we, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [2:0] sx, input logic ack,
                       input logic [31:0] rdata);
    wb_vld_in         = 1'b1;
    wb_kill_in        = 1'b0;
    wb_src_in         = src;
    wb_we_reg_file_in = we;
    wb_rd_in          = rd;
    wb_alu_result_in  = alu;
    wb_sx_type_in     = sx;
    dmem_ack_in       = ack;
    dmem_rdata_in     = rdata;
  endtask

  task automatic quiet();
    wb_vld_in   = 1'b0;
    wb_kill_in  = 1'b0;
    dmem_ack_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && rf_we_out === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {31'b0, rf_we_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_rd", {27'b0, rf_rd_out}, {27'b0, e.rd});
        chk("wr_data", rf_wdata_out, e.data);
        chk("bp_vld", {31'b0, wb_bp_vld_out}, 32'd1);
        chk("bp_rd", {27'b0, wb_bp_rd_out}, {27'b0, e.rd});
        chk("bp_data", wb_bp_data_out, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state();
    chk("rst_we", {31'b0, rf_we_out}, 32'd0);
    chk("rst_rd", {27'b0, rf_rd_out}, 32'd0);
    chk("rst_wdata", rf_wdata_out, 32'd0);
    chk("rst_stall", {31'b0, wb_stall_out}, 32'd0);
    chk("rst_bp_vld", {31'b0, wb_bp_vld_out}, 32'd0);
    chk("rst_bp_rd", {27'b0, wb_bp_rd_out}, 32'd0);
    chk("rst_bp_data", wb_bp_data_out, 32'd0);
    chk("rst_err", {31'b0, wb_err_out}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [4:0]  rd;
    bp_vld_m  = 1'b0;
    bp_rd_m   = 5'd0;
    bp_data_m = 32'd0;
    rst_n = 1'b0;
    quiet();
    wb_src_in = 2'd0; wb_we_reg_file_in = 1'b0; wb_rd_in = 5'd0;
    wb_alu_result_in = 32'd0; wb_sx_imm_in = 32'd0; wb_pc_4_in = 32'd0;
    wb_sx_type_in = 3'd0; dmem_rdata_in = 32'd0;
    #12;
    chk_reset_state();
    rst_n = 1'b1;
    tick();

    // ALU, IMM, PC+4 back to back.
    wb_sx_imm_in = 32'hFFFF_F00D;
    wb_pc_4_in   = 32'h0000_1004;
    drive(2'd0, 1'b1, 5'd5, 32'h1234_5678, 3'd0, 1'b0, 32'd0);
    expect_wr(5'd5, 32'h1234_5678);
    tick();
    chk("alu_we", {31'b0, rf_we_out}, 32'd1);
    chk("alu_bp_rd", {27'b0, wb_bp_rd_out}, 32'd5);
    drive(2'd2, 1'b1, 5'd7, 32'h0, 3'd0, 1'b0, 32'd0);
    expect_wr(5'd7, 32'hFFFF_F00D);
    tick();
    drive(2'd3, 1'b1, 5'd9, 32'h0, 3'd0, 1'b1, 32'hDEAD_BEEF);
    expect_wr(5'd9, 32'h0000_1004);
    tick();
    quiet();
    tick();
    chk("we_pulse", {31'b0, rf_we_out}, 32'd0);

    // LB / LBU, offset 3, ack in the accept cycle.
    drive(2'd1, 1'b1, 5'd3, 32'h0000_1003, 3'b011, 1'b1, 32'h8000_0000);
    expect_wr(5'd3, 32'hFFFF_FF80);
    #1 chk("lb_stall", {31'b0, wb_stall_out}, 32'd0);
    tick();
    drive(2'd1, 1'b1, 5'd4, 32'h0000_1003, 3'b100, 1'b1, 32'h8000_0000);
    expect_wr(5'd4, 32'h0000_0080);
    tick();

    // Every load type and offset, including reserved types.
    for (int sx = 0; sx < 8; sx++) begin
      for (int off = 0; off < 4; off++) begin
        d  = $urandom;
        a  = $urandom;
        a[1:0] = 2'(off);
        rd = 5'((sx * 4 + off) % 31 + 1);
        drive(2'd1, 1'b1, rd, a, 3'(sx), 1'b1, d);
        expect_wr(rd, ref_ld(3'(sx), 2'(off), d));
        tick();
      end
    end
    quiet();
    tick();

    // Ack while idle and no load is accepted is ignored.
    dmem_ack_in = 1'b1;
    tick();
    tick();
    dmem_ack_in = 1'b0;

    // LH, offset 2, ack two cycles after acceptance: stall spans three cycles.
    drive(2'd1, 1'b1, 5'd12, 32'h0000_2002, 3'b001, 1'b0, 32'h0);
    #1 chk("lh_stall0", {31'b0, wb_stall_out}, 32'd1);
    tick();
    chk("lh_stall1", {31'b0, wb_stall_out}, 32'd1);
    tick();
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = 32'h8001_0000;
    expect_wr(5'd12, 32'hFFFF_8001);
    #1 chk("lh_stall2", {31'b0, wb_stall_out}, 32'd1);
    tick();
    quiet();
    #1 chk("lh_stall_low", {31'b0, wb_stall_out}, 32'd0);
    tick();

    // Kill during WAIT with a same-cycle ack: no write.
    drive(2'd1, 1'b1, 5'd6, 32'h0000_3000, 3'b000, 1'b0, 32'h0);
    tick();
    wb_kill_in    = 1'b1;
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = 32'h5555_AAAA;
    tick();
    quiet();
    #1 chk("kill_stall", {31'b0, wb_stall_out}, 32'd0);
    tick();
    chk("kill_no_we", {31'b0, rf_we_out}, 32'd0);

    // rd=0 and we=0: no write, bypass holds its last value.
    drive(2'd0, 1'b1, 5'd0, 32'hCAFE_0000, 3'd0, 1'b0, 32'h0);
    tick();
    drive(2'd0, 1'b0, 5'd8, 32'hCAFE_0008, 3'd0, 1'b0, 32'h0);
    tick();
    quiet();
    tick();
    chk("rd0_we", {31'b0, rf_we_out}, 32'd0);
    chk("rd0_bp_vld", {31'b0, wb_bp_vld_out}, {31'b0, bp_vld_m});
    chk("rd0_bp_rd", {27'b0, wb_bp_rd_out}, {27'b0, bp_rd_m});
    chk("rd0_bp_data", wb_bp_data_out, bp_data_m);

    // Load timeout: ERR after four WAIT cycles, sticky until reset.
    drive(2'd1, 1'b1, 5'd2, 32'h0000_4000, 3'b000, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_err_low", {31'b0, wb_err_out}, 32'd0);
      chk("to_stall", {31'b0, wb_stall_out}, 32'd1);
      tick();
    end
    chk("to_err", {31'b0, wb_err_out}, 32'd1);
    chk("to_err_stall", {31'b0, wb_stall_out}, 32'd1);
    dmem_ack_in = 1'b1;
    wb_kill_in  = 1'b1;
    tick();
    tick();
    chk("err_sticky", {31'b0, wb_err_out}, 32'd1);
    chk("err_stall_sticky", {31'b0, wb_stall_out}, 32'd1);
    quiet();
    #1 rst_n = 1'b0;
    bp_vld_m = 1'b0; bp_rd_m = 5'd0; bp_data_m = 32'd0;
    #1 chk_reset_state();
    rst_n = 1'b1;
    tick();

    // Reset while waiting abandons the load.
    drive(2'd1, 1'b1, 5'd10, 32'h0000_5000, 3'b000, 1'b0, 32'h0);
    tick();
    tick();
    quiet();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = 32'h1111_2222;
    tick();
    tick();
    dmem_ack_in = 1'b0;
    tick();
    chk("abandon_we", {31'b0, rf_we_out}, 32'd0);
    chk("abandon_stall", {31'b0, wb_stall_out}, 32'd0);
    chk("abandon_bp_vld", {31'b0, wb_bp_vld_out}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    chk("n_writes", n_wr, n_exp);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
